// File: rtl/pint_pkg.sv
// Shared state encoding and link constants for the PINT serial master.
// PINT_MASTER_PARITY_EN selects 9-bit frames (byte plus odd parity).
package pint_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BIT  = 3'd1,
        WR_WAIT = 3'd2,
        WR_END  = 3'd3,
        RD_WAIT = 3'd4,
        RD_BIT  = 3'd5,
        RD_DONE = 3'd6
    } pint_state_e;

    localparam int BYTE_W = 8;
`ifdef PINT_MASTER_PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif
    localparam int CLK_DIV_DEF    = 4;
    localparam int RD_TIMEOUT_DEF = 65535;
    localparam int PHASE_W        = 9;

    // Parity bit that makes the count of ones across byte+parity odd.
    function automatic logic odd_par(input logic [BYTE_W-1:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/pint_bit_timer.sv
// Phase counter for one link bit: CLK_DIV cycles low followed by CLK_DIV cycles high.
module pint_bit_timer
    import pint_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic en_i,
    output logic bit_start_o,
    output logic rise_o,
    output logic sample_o
);

    localparam logic [PHASE_W-1:0] LAST_LOW  = PHASE_W'(CLK_DIV - 1);
    localparam logic [PHASE_W-1:0] LAST_HIGH = PHASE_W'(2 * CLK_DIV - 1);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // Next phase: parked at zero while disabled, wraps at the end of each bit.
    always_comb begin
        phase_d = {PHASE_W{1'b0}};
        if (!en_i) begin
            phase_d = {PHASE_W{1'b0}};
        end else if (phase_q == LAST_HIGH) begin
            phase_d = {PHASE_W{1'b0}};
        end else begin
            phase_d = phase_q + {{(PHASE_W-1){1'b0}}, 1'b1};
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q <= {PHASE_W{1'b0}};
        end else begin
            phase_q <= phase_d;
        end
    end

    // rise marks the last low cycle; sample marks the last high cycle.
    assign bit_start_o = en_i && (phase_q == {PHASE_W{1'b0}});
    assign rise_o      = en_i && (phase_q == LAST_LOW);
    assign sample_o    = en_i && (phase_q == LAST_HIGH);

endmodule

// File: rtl/pint_master.sv
// PINT link serial master: MSB-first byte writes, multi-byte reads with timeout, target reset.
// Build option PINT_MASTER_PARITY_EN appends and checks an odd-parity bit per frame.
module pint_master
    import pint_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pint_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       rd_req,
    input  logic [7:0] rd_len,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_done,
    output logic       rd_err,
    output logic       busy,
    output logic       PINT_RESETN,
    output logic       PINT_CLK,
    output logic       PINT_WRREQ,
    output logic       PINT_WRDATA,
    output logic       PINT_RDREQ,
    input  logic       PINT_RDRDY,
    input  logic       PINT_RDDATA
);

    localparam int              TO_W      = $clog2(RD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(RD_TIMEOUT - 1);
    localparam logic [3:0]      FRAME_CNT = 4'(FRAME_LEN);

    pint_state_e     state_q;
    logic            busy_q, tx_ready_q, wrreq_q, wrdata_q, rdreq_q, pclk_q;
    logic            rx_valid_q, rd_done_q, rd_err_q, resetn_q, last_q;
    logic [7:0]      rx_data_q, tx_sh_q, rx_sh_q, len_q;
    logic [3:0]      bit_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            rdy_meta_q, rdy_sync_q, dat_meta_q, dat_sync_q;
    logic            timer_en_s, bit_start_s, rise_s, sample_s, accept_s;

    assign timer_en_s = (state_q == WR_BIT) || (state_q == RD_BIT) || (state_q == WR_END);

    pint_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .en_i        (timer_en_s),
        .bit_start_o (bit_start_s),
        .rise_o      (rise_s),
        .sample_o    (sample_s)
    );

    // A write byte is taken when idle, when waiting, or back-to-back at a frame boundary.
    always_comb begin
        accept_s = 1'b0;
        case (state_q)
            IDLE, WR_WAIT: accept_s = tx_valid;
            WR_BIT:        accept_s = tx_valid && sample_s && (bit_cnt_q == FRAME_CNT) && !last_q;
            default:       accept_s = 1'b0;
        endcase
    end

    // Two-flop synchronisers for the asynchronous target inputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
            dat_meta_q <= 1'b0;
            dat_sync_q <= 1'b0;
        end else begin
            rdy_meta_q <= PINT_RDRDY;
            rdy_sync_q <= rdy_meta_q;
            dat_meta_q <= PINT_RDDATA;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Target reset follows the controller request, independent of link activity.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
        end else begin
            resetn_q <= ~pint_rst;
        end
    end

    // Link FSM with registered pins and handshake pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            wrreq_q    <= 1'b0;
            wrdata_q   <= 1'b0;
            rdreq_q    <= 1'b0;
            pclk_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            last_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            len_q      <= 8'h00;
            bit_cnt_q  <= 4'd0;
            to_cnt_q   <= '0;
        end else begin
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        wrreq_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= WR_BIT;
                    end else if (rd_req && (rd_len != 8'd0)) begin
                        len_q    <= rd_len;
                        rdreq_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= RD_WAIT;
                    end else if (rd_req) begin
                        rd_done_q <= 1'b1;
                    end
                end
                WR_BIT: begin
                    if (bit_start_s) bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (rise_s) pclk_q <= 1'b1;
                    if (sample_s) begin
                        pclk_q <= 1'b0;
                        if (bit_cnt_q == FRAME_CNT) begin
                            bit_cnt_q <= 4'd0;
                            if (last_q)         state_q <= WR_END;
                            else if (!tx_valid) state_q <= WR_WAIT;
                        end else begin
                            wrdata_q <= tx_sh_q[7];
                            tx_sh_q  <= {tx_sh_q[6:0], 1'b0};
                        end
                    end
                end
                WR_WAIT: begin
                    if (tx_valid) state_q <= WR_BIT;
                end
                WR_END: begin
                    if (rise_s) begin
                        wrreq_q  <= 1'b0;
                        wrdata_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (rdy_sync_q) begin
                        bit_cnt_q <= 4'd0;
                        state_q   <= RD_BIT;
                    end else if (to_cnt_q == TO_LAST) begin
                        rdreq_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        rd_err_q  <= 1'b1;
                        rd_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                RD_BIT: begin
                    if (bit_start_s) bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (rise_s) pclk_q <= 1'b1;
                    if (sample_s) begin
                        pclk_q <= 1'b0;
                        if (bit_cnt_q <= 4'd8) rx_sh_q <= {rx_sh_q[6:0], dat_sync_q};
                        if (bit_cnt_q == FRAME_CNT) begin
                            bit_cnt_q  <= 4'd0;
                            rx_valid_q <= 1'b1;
`ifdef PINT_MASTER_PARITY_EN
                            rx_data_q  <= rx_sh_q;
                            rd_err_q   <= (dat_sync_q != odd_par(rx_sh_q));
`else
                            rx_data_q  <= {rx_sh_q[6:0], dat_sync_q};
`endif
                            len_q      <= len_q - 8'd1;
                            if (len_q == 8'd1) state_q <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    rdreq_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    rd_done_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    wrreq_q <= 1'b0;
                    rdreq_q <= 1'b0;
                    pclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            // Loading a byte overrides the shift path; bit 7 goes out on the next low phase.
            if (accept_s) begin
                tx_ready_q <= 1'b1;
                wrdata_q   <= tx_data[7];
                tx_sh_q    <= {tx_data[6:0], odd_par(tx_data)};
                last_q     <= tx_last;
                bit_cnt_q  <= 4'd0;
            end
        end
    end

    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rd_done     = rd_done_q;
    assign rd_err      = rd_err_q;
    assign busy        = busy_q;
    assign PINT_RESETN = resetn_q;
    assign PINT_CLK    = pclk_q;
    assign PINT_WRREQ  = wrreq_q;
    assign PINT_WRDATA = wrdata_q;
    assign PINT_RDREQ  = rdreq_q;

endmodule

// File: tb/tb_pint_master.sv
// Directed bench for pint_master: vector table of single-byte writes/reads plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_pint_master;

    localparam int D   = 4;
    localparam int TMO = 100;
`ifdef PINT_MASTER_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif

    logic       clk = 1'b0, resetn = 1'b0, pint_rst = 1'b0;
    logic [7:0] tx_data = 8'h00, rd_len = 8'h00;
    logic       tx_valid = 1'b0, tx_last = 1'b0, rd_req = 1'b0;
    logic       PINT_RDRDY = 1'b0, PINT_RDDATA = 1'b0;
    logic [7:0] rx_data;
    logic       tx_ready, rx_valid, rd_done, rd_err, busy;
    logic       PINT_RESETN, PINT_CLK, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ;

    int checks = 0;
    int errors = 0;

    pint_master #(.CLK_DIV(D), .RD_TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .pint_rst(pint_rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rd_req(rd_req), .rd_len(rd_len), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_done(rd_done), .rd_err(rd_err), .busy(busy),
        .PINT_RESETN(PINT_RESETN), .PINT_CLK(PINT_CLK), .PINT_WRREQ(PINT_WRREQ),
        .PINT_WRDATA(PINT_WRDATA), .PINT_RDREQ(PINT_RDREQ),
        .PINT_RDRDY(PINT_RDRDY), .PINT_RDDATA(PINT_RDDATA)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Write results
    logic [31:0] w_cap;
    int          w_nbits, w_cyc, w_rdy, w_gapbad;
    logic        w_busy_end;

    task automatic do_write(input logic [7:0] b0, input logic [7:0] b1, input int nbytes, input bit gap);
        int   idx = 0, cyc = 0, gcnt = 0;
        logic prev = 1'b0;
        bit   waiting = 1'b0;
        w_cap = '0; w_nbits = 0; w_cyc = 0; w_rdy = 0; w_gapbad = 0; w_busy_end = 1'b1;
        @(negedge clk);
        tx_data = b0; tx_last = (nbytes == 1); tx_valid = 1'b1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (tx_ready) begin
                w_rdy++; idx++;
                if (idx < nbytes && !gap) begin
                    tx_data = b1; tx_last = 1'b1;
                end else begin
                    tx_valid = 1'b0; tx_last = 1'b0;
                    if (idx < nbytes) waiting = 1'b1;
                end
            end
            if (PINT_WRREQ) w_cyc++;
            if (PINT_CLK && !prev) begin
                w_cap = {w_cap[30:0], PINT_WRDATA};
                w_nbits++;
            end
            prev = PINT_CLK;
            if (waiting && w_nbits == FR && !PINT_CLK) begin
                gcnt++;
                if (PINT_CLK || !PINT_WRREQ) w_gapbad++;
                if (gcnt == 20) begin
                    tx_data = b1; tx_last = 1'b1; tx_valid = 1'b1; waiting = 1'b0;
                end
            end
            if (w_cyc > 0 && !PINT_WRREQ) begin
                w_busy_end = busy;
                break;
            end
        end
        tx_valid = 1'b0;
    endtask

    // Read results
    logic [15:0] r_bytes;
    int          r_nrx, r_nerr, r_treq, r_tdone;
    logic        r_derr, r_dbusy, r_drdreq;

    task automatic do_read(input logic [7:0] len, input int budget);
        int cyc = 1;
        bit done = 1'b0;
        r_bytes = '0; r_nrx = 0; r_nerr = 0; r_treq = -1; r_tdone = -1;
        r_derr = 1'b0; r_dbusy = 1'b1; r_drdreq = 1'b1;
        @(negedge clk);
        rd_len = len; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        while (!done && cyc < budget) begin
            if (PINT_RDREQ && r_treq < 0) r_treq = cyc;
            if (rx_valid) begin
                r_bytes = {r_bytes[7:0], rx_data};
                r_nrx++;
            end
            if (rd_err) r_nerr++;
            if (rd_done) begin
                done = 1'b1; r_tdone = cyc;
                r_derr = rd_err; r_dbusy = busy; r_drdreq = PINT_RDREQ;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    // Target: raises RDRDY after a delay and presents a new bit after every PINT_CLK fall.
    task automatic target(input int delay, input logic [7:0] b0, input logic [7:0] b1, input int nbytes);
        bit   q[$];
        int   w = 0;
        logic prev;
        bit   abort = 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            logic [7:0] b;
            b = (k == 0) ? b0 : b1;
            for (int i = 7; i >= 0; i--) q.push_back(b[i]);
            if (FR == 9) q.push_back(~(^b));
        end
        while (!PINT_RDREQ && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (PINT_RDREQ) begin
            repeat (delay) @(negedge clk);
            PINT_RDRDY = 1'b1;
            PINT_RDDATA = q[0];
            for (int i = 1; i < q.size() && !abort; i++) begin
                w = 0;
                prev = PINT_CLK;
                while (1) begin
                    @(negedge clk);
                    w++;
                    if (!resetn || w >= 200) begin
                        abort = 1'b1;
                        break;
                    end
                    if (prev && !PINT_CLK) break;
                    prev = PINT_CLK;
                end
                if (!abort) PINT_RDDATA = q[i];
            end
            w = 0;
            while (PINT_RDREQ && resetn && w < 500) begin
                @(negedge clk);
                w++;
            end
        end
        PINT_RDRDY = 1'b0;
        PINT_RDDATA = 1'b0;
    endtask

    typedef struct packed {
        logic       is_rd;
        logic [7:0] data;
        logic [7:0] exp_b;
        logic       exp_par;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_frame;
        int          w, rises;
        logic        prev;

        vecs[0] = '{1'b0, 8'hA5, 8'b1010_0101, 1'b1};
        vecs[1] = '{1'b0, 8'h01, 8'b0000_0001, 1'b0};
        vecs[2] = '{1'b0, 8'h80, 8'b1000_0000, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 8'b0000_0000, 1'b1};
        vecs[4] = '{1'b1, 8'h81, 8'h81, 1'b1};
        vecs[5] = '{1'b1, 8'h37, 8'h37, 1'b0};
        vecs[6] = '{1'b1, 8'hFE, 8'hFE, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {15'd0, tx_ready, rx_data, rx_valid, rd_done, rd_err, busy,
               PINT_RESETN, PINT_CLK, PINT_WRREQ, PINT_WRDATA, PINT_RDREQ}, 32'd0);
        resetn = 1'b1;
        #1;
        check("resetn_before_edge", {31'd0, PINT_RESETN}, 32'd0);
        @(negedge clk);
        check("resetn_released", {31'd0, PINT_RESETN}, 32'd1);
        check("pclk_idle_low", {31'd0, PINT_CLK}, 32'd0);

        // pint_rst holds the target in reset without touching the link
        pint_rst = 1'b1;
        @(negedge clk);
        check("pint_rst_assert", {30'd0, PINT_RESETN, busy}, 32'd0);
        pint_rst = 1'b0;
        @(negedge clk);
        check("pint_rst_release", {31'd0, PINT_RESETN}, 32'd1);

        // Vector table: single-byte writes and single-byte reads
        for (int v = 0; v < 7; v++) begin
            if (!vecs[v].is_rd) begin
                do_write(vecs[v].data, 8'h00, 1, 1'b0);
                exp_frame = (FR == 9) ? {23'd0, vecs[v].exp_b, vecs[v].exp_par} : {24'd0, vecs[v].exp_b};
                check($sformatf("wr%0d_bits", v), w_cap, exp_frame);
                check($sformatf("wr%0d_nbits", v), w_nbits, FR);
                check($sformatf("wr%0d_wrreq_cycles", v), w_cyc, 2 * D * FR + D);
                check($sformatf("wr%0d_ready_busy", v), {w_rdy[30:0], w_busy_end}, {31'd1, 1'b0});
            end else begin
                fork
                    target(3, vecs[v].data, 8'h00, 1);
                    do_read(8'd1, 2000);
                join
                check($sformatf("rd%0d_count", v), r_nrx, 1);
                check($sformatf("rd%0d_data", v), {16'd0, r_bytes}, {24'd0, vecs[v].exp_b});
                check($sformatf("rd%0d_done_flags", v), {r_nerr[29:0], r_dbusy, r_drdreq}, 32'd0);
            end
            repeat (6) @(negedge clk);
        end

        // Two-byte write with a 20-cycle stall between bytes
        do_write(8'h3C, 8'hFF, 2, 1'b1);
        exp_frame = (FR == 9) ? {14'd0, 8'h3C, 1'b1, 8'hFF, 1'b1} : {16'd0, 16'h3CFF};
        check("wr2_bits", w_cap, exp_frame);
        check("wr2_ready_pulses", w_rdy, 2);
        check("wr2_wait_hold", w_gapbad, 0);
        check("wr2_wrreq_cycles", w_cyc, 4 * D * FR + 20 + D);
        check("wr2_busy_end", {31'd0, w_busy_end}, 32'd0);
        repeat (6) @(negedge clk);

        // Two-byte read, target ready after 10 cycles
        fork
            target(10, 8'h81, 8'h7E, 2);
            do_read(8'd2, 3000);
        join
        check("rd2_count", r_nrx, 2);
        check("rd2_data", {16'd0, r_bytes}, 32'h0000817E);
        check("rd2_done_seen", {31'd0, (r_tdone > 0)}, 32'd1);
        check("rd2_done_flags", {r_nerr[28:0], r_derr, r_dbusy, r_drdreq}, 32'd0);
        repeat (6) @(negedge clk);

        // Timeout: RDRDY never rises
        do_read(8'd1, 400);
        check("tmo_latency", r_tdone - r_treq, TMO);
        check("tmo_err_with_done", {31'd0, r_derr}, 32'd1);
        check("tmo_idle_after", {30'd0, r_dbusy, r_drdreq}, 32'd0);
        check("tmo_no_rx", r_nrx, 0);
        repeat (6) @(negedge clk);

        // Zero-length read completes without touching the link
        do_read(8'd0, 10);
        check("len0_done_next_cycle", r_tdone, 1);
        check("len0_no_rdreq", r_treq, -1);
        check("len0_not_busy", {31'd0, r_dbusy}, 32'd0);
        repeat (6) @(negedge clk);

        // Reset during the third bit of a read
        fork
            target(5, 8'hC3, 8'h5A, 2);
            begin
                @(negedge clk);
                rd_len = 8'd2; rd_req = 1'b1;
                @(negedge clk);
                rd_req = 1'b0;
                w = 0; rises = 0; prev = 1'b0;
                while (w < 2000 && !(rises >= 2 && !PINT_CLK)) begin
                    @(negedge clk);
                    w++;
                    if (PINT_CLK && !prev) rises++;
                    prev = PINT_CLK;
                end
                check("midrst_reached_bit3", {31'd0, (w < 2000)}, 32'd1);
                #2 resetn = 1'b0;
                #1;
                check("midrst_pins_low", {29'd0, PINT_RDREQ, PINT_CLK, busy}, 32'd0);
                repeat (3) @(negedge clk);
                resetn = 1'b1;
                w = 0; rises = 0;
                repeat (200) begin
                    @(negedge clk);
                    if (rx_valid) w++;
                    if (rd_done) rises++;
                end
                check("midrst_no_rx_valid", w, 0);
                check("midrst_no_rd_done", rises, 0);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
